led_blink_rate_decoder: RTL

Receive-side counterpart of the tutorial LED blink generator. It samples an LED drive line, measures the half-period between transitions, and recovers the 2-bit switch setting that produced the blink rate. It sits on the input side of a board-level loopback or self-check design and reports a validated switch code plus a stuck-line flag.

---
 rtl/led_blink_pkg.sv | 37 +++
 rtl/led_edge_sync.sv | 65 ++++++
 rtl/led_blink_rate_decoder.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/led_blink_pkg.sv
// Shared definitions for the LED blink generator / decoder pair:
// rate code type and constants, default half-period timing, decoder FSM states.
package led_blink_pkg;

  // 2-bit switch code; bit 1 maps to switch 1, bit 0 to switch 2
  typedef logic [1:0] rate_code_t;

  localparam rate_code_t CODE_100HZ = 2'b00;
  localparam rate_code_t CODE_50HZ  = 2'b01;
  localparam rate_code_t CODE_10HZ  = 2'b10;
  localparam rate_code_t CODE_1HZ   = 2'b11;

  // Half-periods in clocks of a 25 kHz system clock
  localparam int DEF_HALF_100HZ = 125;
  localparam int DEF_HALF_50HZ  = 250;
  localparam int DEF_HALF_10HZ  = 1250;
  localparam int DEF_HALF_1HZ   = 12500;

  // Decoder defaults
  localparam int DEF_TOL       = 4;
  localparam int DEF_TIMEOUT   = 25000;
  localparam int DEF_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_CONFIRM = 2'd2,
    ST_LOCKED  = 2'd3
  } state_t;

  // Result of classifying one measured interval
  typedef struct packed {
    logic       hit;
    rate_code_t code;
  } rate_class_t;

endpackage

// File: rtl/led_edge_sync.sv
// Brings the asynchronous LED line into the clock domain and flags every
// transition (rising or falling) as a one-cycle o_edge pulse.
// Build option: LED_BLINK_DECODE_GLITCH_FILTER_EN inserts a 3-sample majority
// filter after the synchronizer, suppressing single-cycle glitches at the cost
// of two extra clocks of latency.
module led_edge_sync (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_led,
  output logic o_edge
);

  logic sync_1;
  logic sync_2;
  logic line;
  logic line_prev;

  // Two-flop synchronizer for the asynchronous pin
  // NOTE: sequential state uses <= so every flop samples pre-edge values; with =
  // sync_2 would see the new sync_1 in the same clock and the chain collapses.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= i_led;
      sync_2 <= sync_1;
    end
  end

`ifdef LED_BLINK_DECODE_GLITCH_FILTER_EN
  logic hist_1;
  logic hist_2;
  logic filt;

  // Majority of the last three synchronized samples, registered
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      hist_1 <= 1'b0;
      hist_2 <= 1'b0;
      filt   <= 1'b0;
    end else begin
      hist_1 <= sync_2;
      hist_2 <= hist_1;
      filt   <= (sync_2 & hist_1) | (sync_2 & hist_2) | (hist_1 & hist_2);
    end
  end

  assign line = filt;
`else
  assign line = sync_2;
`endif

  // Previous-value register for edge detection
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      line_prev <= 1'b0;
    end else begin
      line_prev <= line;
    end
  end

  assign o_edge = line ^ line_prev;

endmodule

// File: rtl/led_blink_rate_decoder.sv
// Recovers the 2-bit switch code from an LED blink line by timing the
// half-period between transitions. A code is reported (o_valid) only after two
// consecutive matching half-periods; o_stuck flags a line with no transitions
// for TIMEOUT clocks.
// Build option: LED_BLINK_DECODE_GLITCH_FILTER_EN (see led_edge_sync).
module led_blink_rate_decoder
  import led_blink_pkg::*;
#(
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int HALF_100HZ = DEF_HALF_100HZ,
  parameter int HALF_50HZ  = DEF_HALF_50HZ,
  parameter int HALF_10HZ  = DEF_HALF_10HZ,
  parameter int HALF_1HZ   = DEF_HALF_1HZ,
  parameter int TOL        = DEF_TOL,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_led,
  output logic o_switch_1,
  output logic o_switch_2,
  output logic o_valid,
  output logic o_stuck
);

  // Match windows must be disjoint and ordered, the timeout must lie beyond
  // the slowest window, and the counter must be able to hold the timeout.
  if ((HALF_100HZ + TOL >= HALF_50HZ - TOL) ||
      (HALF_50HZ  + TOL >= HALF_10HZ - TOL) ||
      (HALF_10HZ  + TOL >= HALF_1HZ  - TOL) ||
      (TOL < 0)) begin : g_bad_windows
    $error("led_blink_rate_decoder: interval match windows overlap");
  end
  if ((TIMEOUT <= HALF_1HZ + TOL + 1) ||
      (longint'(TIMEOUT) >= (longint'(1) << CNT_WIDTH))) begin : g_bad_timeout
    $error("led_blink_rate_decoder: TIMEOUT out of range for windows or CNT_WIDTH");
  end

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CNT_PRE = CNT_WIDTH'(TIMEOUT - 1);

  logic                 edge_det;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 timeout_hit;
  rate_class_t          cls;

  state_t               state;
  state_t               state_d;
  rate_code_t           cand;
  rate_code_t           cand_d;
  rate_code_t           sw_q;
  logic                 valid_d;
  logic                 sw_load;
  logic                 stuck_d;

  led_edge_sync u_edge_sync (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_led     (i_led),
    .o_edge    (edge_det)
  );

  // Interval counter: restarts at 1 on each edge, saturates at TIMEOUT
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt <= '0;
    end else if (edge_det) begin
      cnt <= CNT_ONE;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // An edge arriving on the same clock overrides the timeout
  assign timeout_hit = !edge_det && (cnt == CNT_PRE);

  function automatic logic near(input logic [CNT_WIDTH-1:0] n, input int half);
    int diff;
    diff = int'(n) - half;
    return (diff >= -TOL) && (diff <= TOL);
  endfunction

  // Classify the interval that ends at the current edge
  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    cls = '{hit: 1'b0, code: CODE_100HZ};
    if (near(cnt, HALF_100HZ)) begin
      cls = '{hit: 1'b1, code: CODE_100HZ};
    end else if (near(cnt, HALF_50HZ)) begin
      cls = '{hit: 1'b1, code: CODE_50HZ};
    end else if (near(cnt, HALF_10HZ)) begin
      cls = '{hit: 1'b1, code: CODE_10HZ};
    end else if (near(cnt, HALF_1HZ)) begin
      cls = '{hit: 1'b1, code: CODE_1HZ};
    end
  end

  // State, candidate and registered outputs
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= ST_IDLE;
      cand    <= CODE_100HZ;
      sw_q    <= CODE_100HZ;
      o_valid <= 1'b0;
      o_stuck <= 1'b0;
    end else begin
      state   <= state_d;
      cand    <= cand_d;
      o_valid <= valid_d;
      o_stuck <= stuck_d;
      if (sw_load) begin
        sw_q <= cand_d;
      end
    end
  end

  // Next-state: a code must repeat on two consecutive intervals to lock
  always_comb begin
    state_d = state;
    cand_d  = cand;
    if (edge_det) begin
      unique case (state)
        ST_IDLE: begin
          state_d = ST_MEASURE;
        end
        ST_MEASURE: begin
          if (cls.hit) begin
            state_d = ST_CONFIRM;
            cand_d  = cls.code;
          end
        end
        ST_CONFIRM: begin
          if (!cls.hit) begin
            state_d = ST_MEASURE;
          end else if (cls.code == cand) begin
            state_d = ST_LOCKED;
          end else begin
            cand_d = cls.code;
          end
        end
        ST_LOCKED: begin
          if (!cls.hit) begin
            state_d = ST_MEASURE;
          end else if (cls.code != cand) begin
            state_d = ST_CONFIRM;
            cand_d  = cls.code;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else if (timeout_hit && (state != ST_IDLE)) begin
      state_d = ST_IDLE;
    end
  end

  // Output decode from the upcoming state
  always_comb begin
    valid_d = (state_d == ST_LOCKED);
    sw_load = (state_d == ST_LOCKED) && (state != ST_LOCKED);
    stuck_d = o_stuck;
    if (timeout_hit) begin
      stuck_d = 1'b1;
    end else if (edge_det) begin
      stuck_d = 1'b0;
    end
  end

  assign o_switch_1 = sw_q[1];
  assign o_switch_2 = sw_q[0];

endmodule
